// File: rtl/ex_mem_stage_if.sv
// ----------------------------------------------------------------------------
// ex_mem_stage_if
//
// Purpose:
//   Bundles the upstream (operation in) and downstream (result out)
//   valid/ready channels of the execute/memory stage. The stage connects
//   through the slave modport. Whatever drives operations and consumes
//   results connects through the master modport.
//
// Signals:
//   in_valid / in_ready   upstream handshake (an op is accepted when both are 1)
//   alu_op[2:0]           000 PASS, 001 INC, 010 NEG, 011 SUB, 100 ADD, others reserved
//   alu_src               0: operand B = rd2, 1: operand B = imm
//   mem_read / mem_write  load / store at address = ALU result
//   rd1, rd2, imm         operand A, operand B candidate / store data, immediate
//   out_valid / out_ready downstream handshake
//   result, read_data     registered ALU result and loaded word
//   zero, neg, addr_err   flags describing the registered result
//   ovf                   signed overflow flag (only with OVERFLOW_FLAG_EN)
//
// Configuration macro: OVERFLOW_FLAG_EN adds the ovf signal.
// ----------------------------------------------------------------------------
interface ex_mem_stage_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        alu_op;
    logic              alu_src;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] read_data;
    logic              zero;
    logic              neg;
    logic              addr_err;
`ifdef OVERFLOW_FLAG_EN
    logic              ovf;
`endif

`ifdef OVERFLOW_FLAG_EN
    modport master (
        output in_valid, alu_op, alu_src, mem_read, mem_write, rd1, rd2, imm,
        output out_ready,
        input  in_ready, out_valid, result, read_data, zero, neg, addr_err, ovf
    );

    modport slave (
        input  in_valid, alu_op, alu_src, mem_read, mem_write, rd1, rd2, imm,
        input  out_ready,
        output in_ready, out_valid, result, read_data, zero, neg, addr_err, ovf
    );
`else
    modport master (
        output in_valid, alu_op, alu_src, mem_read, mem_write, rd1, rd2, imm,
        output out_ready,
        input  in_ready, out_valid, result, read_data, zero, neg, addr_err
    );

    modport slave (
        input  in_valid, alu_op, alu_src, mem_read, mem_write, rd1, rd2, imm,
        input  out_ready,
        output in_ready, out_valid, result, read_data, zero, neg, addr_err
    );
`endif

endinterface

// File: rtl/ex_mem_stage.sv
// ----------------------------------------------------------------------------
// ex_mem_stage
//
// Purpose:
//   Execute/memory pipeline stage between decode/register-read and
//   writeback. It computes an ALU result and flags, then optionally performs
//   one access to a synchronous data memory at address = ALU result. The
//   result is held in an output register until downstream takes it.
//   Valid/ready handshakes are used on both sides.
//
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      ex_mem_stage_if.slave. It carries the upstream op channel
//            (in_valid/in_ready, alu_op, alu_src, mem_read, mem_write, rd1,
//            rd2, imm) and the downstream result channel (out_valid/out_ready,
//            result, read_data, zero, neg, addr_err[, ovf]).
//
// Parameters:
//   DATA_W  datapath width (operands, result, memory words)
//   DEPTH   number of data memory words
//   ADDR_W  memory index width, 2**ADDR_W >= DEPTH, ADDR_W <= DATA_W
//
// Configuration macro:
//   OVERFLOW_FLAG_EN  when defined, adds a registered signed-overflow flag
//                     (bus.ovf) for ADD, SUB, INC and NEG.
//
// Timing:
//   ALU-only ops present out_valid the cycle after accept and can stream at
//   one per cycle. Memory ops spend one extra cycle in MEM, so out_valid
//   appears two cycles after accept. An erroring memory op skips MEM.
// ----------------------------------------------------------------------------
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic           clock,
    input  logic           reset_n,
    ex_mem_stage_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MEM  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_NEG  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;

    localparam int MSB = DATA_W - 1;

    // The depth is widened by one bit so that the range check compares the
    // whole result. Truncating the address first would let large results
    // alias onto valid words.
    localparam logic [DATA_W:0] DEPTH_EXT = (DATA_W+1)'(DEPTH);

    logic [1:0]        state;

    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_res;
    logic              alu_reserved;
    logic              mem_op;
    logic              out_of_range;
    logic              next_err;
    logic              go_mem;
    logic              accept;

    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] read_data_q;
    logic              zero_q;
    logic              neg_q;
    logic              err_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [DATA_W-1:0] store_data_q;
    logic [ADDR_W-1:0] mem_addr;

    logic [DATA_W-1:0] mem [DEPTH];

`ifdef OVERFLOW_FLAG_EN
    logic              alu_ovf;
    logic              ovf_q;
`endif

    // Operand B selection and the ALU itself. Reserved opcodes produce a
    // zero result and are flagged so they never reach the memory.
    always_comb begin
        op_b         = bus.alu_src ? bus.imm : bus.rd2;
        alu_res      = '0;
        alu_reserved = 1'b0;
        case (bus.alu_op)
            OP_PASS: alu_res = bus.rd1;
            OP_INC:  alu_res = bus.rd1 + DATA_W'(1);
            OP_NEG:  alu_res = '0 - bus.rd1;
            OP_SUB:  alu_res = bus.rd1 - op_b;
            OP_ADD:  alu_res = bus.rd1 + op_b;
            default: alu_reserved = 1'b1;
        endcase
    end

`ifdef OVERFLOW_FLAG_EN
    // Signed overflow from operand and result sign bits. INC overflows only
    // when A is the largest positive value. NEG overflows only when A is the
    // most negative value, which is the one case where A and -A are both
    // negative.
    always_comb begin
        alu_ovf = 1'b0;
        case (bus.alu_op)
            OP_INC:  alu_ovf = ~bus.rd1[MSB] & alu_res[MSB];
            OP_NEG:  alu_ovf = bus.rd1[MSB] & alu_res[MSB];
            OP_SUB:  alu_ovf = (bus.rd1[MSB] ^ op_b[MSB]) & (alu_res[MSB] ^ bus.rd1[MSB]);
            OP_ADD:  alu_ovf = ~(bus.rd1[MSB] ^ op_b[MSB]) & (alu_res[MSB] ^ bus.rd1[MSB]);
            default: alu_ovf = 1'b0;
        endcase
    end
`endif

    // Error classification and routing of an op about to be accepted. A
    // memory op is sent to MEM only when it is error-free. Otherwise it
    // goes straight to HOLD with read_data forced to zero.
    always_comb begin
        mem_op       = bus.mem_read | bus.mem_write;
        out_of_range = ({1'b0, alu_res} >= DEPTH_EXT);
        next_err     = alu_reserved | (mem_op & out_of_range);
        go_mem       = mem_op & ~next_err;
    end

    // In HOLD a new op can enter in the same cycle as the held result leaves.
    // This is what gives one-per-cycle throughput for ALU-only streams.
    // Nothing is accepted while reset is asserted.
    assign bus.in_ready  = reset_n &
                           ((state == ST_IDLE) | ((state == ST_HOLD) & bus.out_ready));
    assign bus.out_valid = (state == ST_HOLD);
    assign accept        = bus.in_valid & bus.in_ready;

    // Stage control. MEM always lasts one cycle. HOLD lasts until downstream
    // takes the result. At that point it either chains straight into the
    // next accepted op or returns to IDLE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= go_mem ? ST_MEM : ST_HOLD;
                    end
                end
                ST_MEM: begin
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (accept) begin
                        state <= go_mem ? ST_MEM : ST_HOLD;
                    end else if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output and operation registers. Everything is captured at accept, so
    // the outputs cannot change while a result waits in HOLD. read_data is
    // cleared at accept and is loaded only by a load in MEM. Non-loads and
    // erroring ops therefore report zero. Flags come from the ALU result,
    // never from loaded data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_q     <= '0;
            read_data_q  <= '0;
            zero_q       <= 1'b0;
            neg_q        <= 1'b0;
            err_q        <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            store_data_q <= '0;
        end else if (accept) begin
            result_q     <= alu_res;
            read_data_q  <= '0;
            zero_q       <= (alu_res == '0);
            neg_q        <= alu_res[MSB];
            err_q        <= next_err;
            mem_read_q   <= bus.mem_read & go_mem;
            mem_write_q  <= bus.mem_write & go_mem;
            store_data_q <= bus.rd2;
        end else if ((state == ST_MEM) && mem_read_q) begin
            read_data_q  <= mem[mem_addr];
        end
    end

`ifdef OVERFLOW_FLAG_EN
    // The overflow flag travels with the result it describes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= alu_ovf;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    // The registered result is known to be in range whenever MEM is entered,
    // so its low bits are a valid index.
    assign mem_addr = result_q[ADDR_W-1:0];

    // Data memory write port. It has no reset, so contents survive reset.
    // The write happens on the edge that leaves MEM. The read above uses the
    // same edge and sees the old word, which gives read-before-write when
    // both controls are set. An asynchronous reset during MEM puts the state
    // back in IDLE before that edge, so the pending store is dropped.
    always_ff @(posedge clock) begin
        if ((state == ST_MEM) && mem_write_q) begin
            mem[mem_addr] <= store_data_q;
        end
    end

    assign bus.result    = result_q;
    assign bus.read_data = read_data_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.addr_err  = err_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_mem_stage
//
// Scoreboard bench for ex_mem_stage. Each accepted op is run through a
// reference model that works on signed 64-bit arithmetic and an array copy
// of memory. The expected response is queued. A separate monitor pops one
// entry whenever a result transfers downstream, and it also checks that the
// outputs are held steady under backpressure.
// ----------------------------------------------------------------------------
module tb_ex_mem_stage;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    localparam longint S_MAX = 64'sd2147483647;
    localparam longint S_MIN = -64'sd2147483648;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] rdata;
        logic        zero;
        logic        neg;
        logic        err;
        logic        ovf;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    ex_mem_stage_if #(.DATA_W(DATA_W)) bus ();

    ex_mem_stage #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    exp_t        sb[$];
    logic [31:0] mem_model [DEPTH];
    int          tests_run    = 0;
    int          tests_failed = 0;
    int          rdy_mode     = 0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic actual, input logic expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: signed arithmetic in 64 bits, truncated to 32 bits.
    // Overflow means the exact signed answer does not fit in 32 bits.
    function automatic exp_t model_op(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic mrd,
                                      input logic mwr, input logic [31:0] sd);
        longint sa, sbv, s;
        bit     reserved;
        exp_t   e;
        reserved = 1'b0;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (op)
            3'd0:    s = sa;
            3'd1:    s = sa + 1;
            3'd2:    s = -sa;
            3'd3:    s = sa - sbv;
            3'd4:    s = sa + sbv;
            default: begin s = 0; reserved = 1'b1; end
        endcase
        e.result = s[31:0];
        e.ovf    = (s > S_MAX) || (s < S_MIN);
        e.zero   = (e.result == 32'd0);
        e.neg    = e.result[31];
        e.err    = reserved || ((mrd || mwr) && (longint'(e.result) >= longint'(DEPTH)));
        e.rdata  = 32'd0;
        if ((mrd || mwr) && !e.err) begin
            if (mrd) e.rdata = mem_model[e.result[7:0]];
            if (mwr) mem_model[e.result[7:0]] = sd;
        end
        return e;
    endfunction

    // Present one op from a negedge and wait (bounded) for it to be
    // accepted. abandon=1 marks an op that reset will kill. Such an op gets
    // no expected response and does not change the model memory.
    task automatic apply_stimulus(input logic [2:0] op, input logic src, input logic mrd,
                                  input logic mwr, input logic [31:0] a, input logic [31:0] b2,
                                  input logic [31:0] im, input bit abandon);
        bit acc;
        acc = 1'b0;
        @(negedge clock);
        bus.in_valid  = 1'b1;
        bus.alu_op    = op;
        bus.alu_src   = src;
        bus.mem_read  = mrd;
        bus.mem_write = mwr;
        bus.rd1       = a;
        bus.rd2       = b2;
        bus.imm       = im;
        for (int i = 0; i < 100; i++) begin
            #4;
            if (bus.in_ready) begin
                acc = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!acc) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0, required 1 within 100 cycles");
            bus.in_valid = 1'b0;
            return;
        end
        if (!abandon) begin
            sb.push_back(model_op(op, a, src ? im : b2, mrd, mwr, b2));
        end
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL drain_timeout: %0d results pending, required 0", sb.size());
        end
        @(posedge clock);
        #1;
    endtask

    // Downstream ready generator: 0 = always ready, 1 = random, 2 = stalled.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clock);
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                2:       bus.out_ready = 1'b0;
                default: bus.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: samples just before each rising edge.
    initial begin
        exp_t        e;
        bit          stalled;
        logic [31:0] held_res, held_rd;
        logic [2:0]  held_flags;
        stalled = 1'b0;
        held_res = '0;
        held_rd = '0;
        held_flags = '0;
        forever begin
            @(negedge clock);
            #4;
            if (!reset_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled && bus.out_valid) begin
                    check_output("hold_result", bus.result, held_res);
                    check_output("hold_read_data", bus.read_data, held_rd);
                    check_output("hold_flags", {29'd0, bus.zero, bus.neg, bus.addr_err},
                                 {29'd0, held_flags});
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("[TB] FAIL unexpected_output: result 0x%08h with empty scoreboard", bus.result);
                    end else begin
                        e = sb.pop_front();
                        check_output("result", bus.result, e.result);
                        check_output("read_data", bus.read_data, e.rdata);
                        check_bit("zero", bus.zero, e.zero);
                        check_bit("neg", bus.neg, e.neg);
                        check_bit("addr_err", bus.addr_err, e.err);
`ifdef OVERFLOW_FLAG_EN
                        check_bit("ovf", bus.ovf, e.ovf);
`endif
                    end
                end
                stalled    = bus.out_valid && !bus.out_ready;
                held_res   = bus.result;
                held_rd    = bus.read_data;
                held_flags = {bus.zero, bus.neg, bus.addr_err};
            end
        end
    end

    initial begin
        logic [2:0]  op;
        logic        mrd, mwr, src;
        logic [31:0] a, b, im;
        int          r;

        bus.in_valid  = 1'b0;
        bus.alu_op    = 3'd0;
        bus.alu_src   = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.rd1       = '0;
        bus.rd2       = '0;
        bus.imm       = '0;

        #2;
        check_bit("reset_out_valid", bus.out_valid, 1'b0);
        check_bit("reset_in_ready", bus.in_ready, 1'b0);
        check_output("reset_result", bus.result, 32'd0);
        check_output("reset_read_data", bus.read_data, 32'd0);
        check_output("reset_flags", {29'd0, bus.zero, bus.neg, bus.addr_err}, 32'd0);
`ifdef OVERFLOW_FLAG_EN
        check_bit("reset_ovf", bus.ovf, 1'b0);
`endif
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        apply_stimulus(3'd4, 1'b1, 1'b0, 1'b0, 32'd5, 32'd0, 32'd3, 1'b0);
        check_bit("alu_latency", bus.out_valid, 1'b1);
        apply_stimulus(3'd3, 1'b0, 1'b0, 1'b0, 32'd3, 32'd5, 32'd0, 1'b0);
        apply_stimulus(3'd3, 1'b0, 1'b0, 1'b0, 32'd7, 32'd7, 32'd0, 1'b0);

        for (int i = 0; i < 64; i++) begin
            apply_stimulus(3'd0, 1'b0, 1'b0, 1'b1, 32'(i), $urandom, 32'd0, 1'b0);
        end

        drain(50);
        apply_stimulus(3'd4, 1'b1, 1'b0, 1'b1, 32'd2, 32'h0000DEAD, 32'd1, 1'b0);
        check_bit("mem_latency_mem", bus.out_valid, 1'b0);
        @(posedge clock);
        #1 check_bit("mem_latency_hold", bus.out_valid, 1'b1);
        apply_stimulus(3'd4, 1'b1, 1'b1, 1'b0, 32'd2, 32'd0, 32'd1, 1'b0);

        drain(50);
        apply_stimulus(3'd4, 1'b1, 1'b1, 1'b0, 32'd300, 32'd0, 32'd0, 1'b0);
        check_bit("oor_latency", bus.out_valid, 1'b1);
        apply_stimulus(3'd0, 1'b0, 1'b0, 1'b1, 32'd300, 32'h12345678, 32'd0, 1'b0);
        apply_stimulus(3'd0, 1'b0, 1'b1, 1'b0, 32'd44, 32'd0, 32'd0, 1'b0);
        apply_stimulus(3'd6, 1'b0, 1'b1, 1'b0, 32'd9, 32'd4, 32'd0, 1'b0);
        apply_stimulus(3'd0, 1'b0, 1'b1, 1'b1, 32'd10, 32'h0000CAFE, 32'd0, 1'b0);
        apply_stimulus(3'd0, 1'b0, 1'b1, 1'b0, 32'd10, 32'd0, 32'd0, 1'b0);

        apply_stimulus(3'd4, 1'b1, 1'b0, 1'b0, 32'h7FFFFFFF, 32'd0, 32'd1, 1'b0);
        apply_stimulus(3'd2, 1'b0, 1'b0, 1'b0, 32'h80000000, 32'd0, 32'd0, 1'b0);
        apply_stimulus(3'd4, 1'b1, 1'b0, 1'b0, 32'd1, 32'd0, 32'd1, 1'b0);
        apply_stimulus(3'd1, 1'b0, 1'b0, 1'b0, 32'h7FFFFFFF, 32'd0, 32'd0, 1'b0);
        apply_stimulus(3'd3, 1'b0, 1'b0, 1'b0, 32'h80000000, 32'd1, 32'd0, 1'b0);

        drain(50);
        rdy_mode = 2;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    apply_stimulus(3'd4, 1'b0, 1'b0, 1'b0, $urandom, $urandom, 32'd0, 1'b0);
                end
            end
            begin
                repeat (4) @(negedge clock);
                #4;
                check_bit("stall_in_ready", bus.in_ready, 1'b0);
                check_bit("stall_out_valid", bus.out_valid, 1'b1);
                rdy_mode = 0;
            end
        join

        drain(50);
        apply_stimulus(3'd0, 1'b0, 1'b0, 1'b1, 32'd20, 32'h00001111, 32'd0, 1'b0);
        apply_stimulus(3'd0, 1'b0, 1'b0, 1'b1, 32'd20, 32'h00002222, 32'd0, 1'b1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_bit("midreset_out_valid", bus.out_valid, 1'b0);
        check_bit("midreset_in_ready", bus.in_ready, 1'b0);
        check_output("midreset_result", bus.result, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        apply_stimulus(3'd0, 1'b0, 1'b1, 1'b0, 32'd20, 32'd0, 32'd0, 1'b0);

        rdy_mode = 1;
        for (int n = 0; n < 300; n++) begin
            r   = $urandom_range(0, 15);
            mrd = 1'b0;
            mwr = 1'b0;
            src = $urandom_range(0, 1);
            a   = $urandom;
            b   = $urandom;
            im  = $urandom;
            op  = 3'($urandom_range(0, 4));
            if (r < 6) begin
                mrd = $urandom_range(0, 1);
                mwr = !mrd || ($urandom_range(0, 3) == 0);
                if (r == 0) begin
                    op = 3'($urandom_range(5, 7));
                end else if (r == 1) begin
                    op = 3'd4;
                    src = 1'b1;
                    a = 32'($urandom_range(256, 5000));
                    im = 32'd0;
                end else begin
                    op = 3'd4;
                    src = 1'b1;
                    a = 32'($urandom_range(0, 31));
                    im = 32'($urandom_range(0, 31));
                end
            end else if (r == 6) begin
                a = 32'h80000000;
            end else if (r == 7) begin
                a = 32'h7FFFFFFF;
            end else if (r == 8) begin
                b = a;
                im = a;
            end else if (r == 9) begin
                op = 3'($urandom_range(5, 7));
            end
            if ($urandom_range(0, 3) == 0) @(posedge clock);
            apply_stimulus(op, src, mrd, mwr, a, b, im, 1'b0);
        end

        rdy_mode = 0;
        drain(500);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Parametrised execute/memory stage: ALU, flag generation and a synchronous data memory behind a valid/ready handshake on both sides.
- Sits between register read/decode and writeback.
- Memory address is the ALU result (base + offset); store data is rd2.
- Output register holds results under backpressure.

Parameters:
DATA_W, 32, datapath width of operands, result, memory words
DEPTH, 256, number of data memory words
ADDR_W, 8, memory index width; must satisfy 2^ADDR_W >= DEPTH

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream has an operation
in_ready  output  1  stage accepts an operation this cycle
alu_op  input  3  000 PASS(A), 001 INC(A+1), 010 NEG(-A), 011 SUB(A-B), 100 ADD(A+B), 101-111 reserved
alu_src  input  1  0: B=rd2, 1: B=imm
mem_read  input  1  load from address=ALU result
mem_write  input  1  store rd2 to address=ALU result
rd1  input  DATA_W  operand A
rd2  input  DATA_W  operand B candidate / store data
imm  input  DATA_W  immediate operand B candidate
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
result  output  DATA_W  ALU result (registered)
read_data  output  DATA_W  loaded word (0 if no load)
zero  output  1  result == 0
neg  output  1  result[DATA_W-1]
addr_err  output  1  memory op with result >= DEPTH, or reserved alu_op

Behaviour:
- Reset:
  - State goes to IDLE asynchronously on reset_n low.
  - in_ready=0 while in reset; out_valid=0.
  - result, read_data, zero, neg and addr_err are all 0.
  - Memory contents are not reset.
  - Reset in MEM abandons the pending access: no write occurs.
- Arithmetic is modulo 2^DATA_W, two's complement. NEG of most-negative returns the same value. Reserved ops give result=0 and addr_err=1, with no memory access.
- Flags describe the ALU result, never the loaded data.
- Accept means in_valid && in_ready. On accept, the stage registers:
  - the ALU result and flags;
  - the op controls (mem_read, mem_write);
  - rd2 as store data.
- States:
  - IDLE: in_ready=1, out_valid=0. On accept: go to MEM if mem_read|mem_write (and no error), else go to HOLD.
  - MEM: in_ready=0, out_valid=0. The memory access occurs on this clock edge. Next state HOLD.
  - HOLD: out_valid=1, in_ready=out_ready. On out_ready: if in_valid, accept the new op (same routing as IDLE); else go to IDLE.
- Latency and throughput:
  - ALU-only ops: out_valid on the cycle after accept; throughput 1 per cycle.
  - Memory ops: out_valid 2 cycles after accept.
- Outputs are stable while out_valid && !out_ready.
- mem_read and mem_write both set: read-before-write. read_data returns the old word and the memory then holds rd2.
- Address out of range (result >= DEPTH) on a memory op:
  - no write;
  - read_data=0, addr_err=1;
  - skips MEM and goes straight to HOLD.
- Address uses the full result compare, not truncation.
- read_data=0 for non-load ops.

Optional Feature:
- Macro OVERFLOW_FLAG_EN.
- Defined: extra output ovf (1 bit), registered with the result. It is the signed overflow for:
  - ADD and SUB;
  - INC of max-positive;
  - NEG of most-negative.
  ovf=0 for PASS and reserved ops; reset value 0.
- Undefined: the port is absent and no overflow logic exists.

Test Plan:
- Reset mid-op: store accepted, reset_n low while in MEM → out_valid=0, in_ready=0 during reset; afterwards a load of the same address returns the previous contents (no write).
- ADD: rd1=5, imm=3, alu_src=1 → next cycle out_valid=1, result=8, zero=0, neg=0. SUB rd1=3, rd2=5 → result=0xFFFFFFFE, neg=1. SUB 7-7 → zero=1.
- Store/load: rd1=2, imm=1, rd2=0xDEAD, mem_write → then a load at the same address gives read_data=0x0000DEAD two cycles after accept, with result=3.
- Backpressure: back-to-back ADDs with out_ready=0 for 3 cycles → result/flags frozen, in_ready=0. On release, one result per cycle and no op lost or duplicated.
- Out-of-range: DEPTH=256, load/store to address 300 → addr_err=1, read_data=0, out_valid one cycle after accept. A load at 44 is unchanged. alu_op=110 → result=0, addr_err=1.
- With OVERFLOW_FLAG_EN: ADD 0x7FFFFFFF+1 → ovf=1, neg=1. NEG 0x80000000 → result=0x80000000, ovf=1. ADD 1+1 → ovf=0.
